// File: rtl/brq_instr_mem_resp.sv
// Instruction-fetch bus responder: grants pipelined word reads against an
// outstanding limit, drives a synchronous SRAM and returns in-order responses.
module brq_instr_mem_resp #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter logic [31:0] MemSizeBytes   = 32'h0001_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrW          = 14
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             stall_i,
    output logic             mem_req_o,
    output logic [AddrW-1:0] mem_addr_o,
    input  logic [31:0]      mem_rdata_i
);
    localparam int unsigned CntW = 3;

    logic [CntW-1:0]        r_cnt;
    logic [ReadLatency-1:0] r_vld;
    logic [ReadLatency-1:0] r_err;

    logic        w_fire;
    logic        w_gnt;
    logic        w_hit;
    logic        w_aligned;
    logic        w_ok;
    logic [31:0] w_off;
    logic [31:0] w_data;

    // Window decode on the unsigned offset: addresses below the base wrap and miss.
    assign w_off     = instr_addr_i - MemBase;
    assign w_hit     = (w_off < MemSizeBytes);
    assign w_aligned = (instr_addr_i[1:0] == 2'b00);
    assign w_ok      = w_hit & w_aligned;

    assign w_fire = r_vld[ReadLatency-1];
    assign w_gnt  = instr_req_i & ~stall_i
                  & ((r_cnt < CntW'(MaxOutstanding)) | w_fire);

    assign instr_gnt_o = w_gnt;
    assign mem_req_o   = w_gnt & w_ok;
    assign mem_addr_o  = w_off[AddrW+1:2];

    // Outstanding-transaction counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(w_gnt) - CntW'(w_fire);
        end
    end

    // Response tag pipeline {valid, err}; the last stage is the bus output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_err <= '0;
        end else begin
            r_vld[0] <= w_gnt;
            r_err[0] <= w_gnt & ~w_ok;
            for (int i = 1; i < ReadLatency; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    generate
        if (ReadLatency > 1) begin : g_data_regs
            logic [31:0] r_data [ReadLatency-1];

            // SRAM word is captured the cycle after its read and follows its tag.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < ReadLatency - 1; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    if (r_vld[0] & ~r_err[0]) begin
                        r_data[0] <= mem_rdata_i;
                    end
                    for (int i = 1; i < ReadLatency - 1; i++) begin
                        if (r_vld[i]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign w_data = r_data[ReadLatency-2];
        end else begin : g_data_bypass
            // Single-cycle latency: the SRAM output register is the data stage.
            assign w_data = mem_rdata_i;
        end
    endgenerate

    assign instr_rvalid_o = r_vld[ReadLatency-1];
    assign instr_err_o    = r_err[ReadLatency-1];
    assign instr_rdata_o  = (instr_rvalid_o & ~instr_err_o) ? w_data : 32'h0;

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_cnt <= CntW'(MaxOutstanding));

    fire_has_owner_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_fire |-> (r_cnt != '0));

endmodule

// File: tb/tb_brq_instr_mem_resp.sv
// Scoreboard bench for brq_instr_mem_resp: three instances with different
// latency/outstanding/base settings, each checked every cycle against a model.
module tb_brq_instr_mem_resp;
    localparam int unsigned NDut = 3;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        done = 1'b0;

    logic        req_a   [NDut];
    logic [31:0] addr_a  [NDut];
    logic        stall_a [NDut];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%08h exp=0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sram_word(input logic [13:0] wa);
        return 32'h0000_0013 ^ {wa, 2'b00, wa, 2'b00};
    endfunction

    function automatic logic [31:0] base_of(input int g);
        return (g == 1) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    generate
        for (genvar g = 0; g < NDut; g++) begin : g_dut
            localparam int unsigned Rl   = (g == 0) ? 1 : (g == 1) ? 3 : 2;
            localparam int unsigned Mo   = (g == 1) ? 1 : 2;
            localparam logic [31:0] Base = (g == 1) ? 32'h0000_0100 : 32'h0000_0000;

            logic        gnt;
            logic        rvalid;
            logic        err;
            logic        mreq;
            logic [31:0] rdata;
            logic [31:0] mrdata;
            logic [13:0] maddr;

            exp_t        sb[$];
            exp_t        e;
            int unsigned mcnt = 0;
            logic        fire;
            logic        hit;
            logic        algn;
            logic        egnt;
            logic        drained = 1'b0;
            logic [31:0] off;

            brq_instr_mem_resp #(
                .MemBase        (Base),
                .MemSizeBytes   (32'h0001_0000),
                .ReadLatency    (Rl),
                .MaxOutstanding (Mo),
                .AddrW          (14)
            ) u_dut (
                .clk_i          (clk),
                .rst_ni         (rst_n),
                .instr_req_i    (req_a[g]),
                .instr_addr_i   (addr_a[g]),
                .instr_gnt_o    (gnt),
                .instr_rvalid_o (rvalid),
                .instr_rdata_o  (rdata),
                .instr_err_o    (err),
                .stall_i        (stall_a[g]),
                .mem_req_o      (mreq),
                .mem_addr_o     (maddr),
                .mem_rdata_i    (mrdata)
            );

            // Synchronous SRAM model with fixed, address-derived contents.
            always @(posedge clk) begin
                if (mreq) mrdata <= sram_word(maddr);
            end

            always @(negedge clk) begin
                if (!rst_n) begin
                    sb.delete();
                    mcnt = 0;
                    check_eq($sformatf("d%0d.rst_rvalid", g), 32'(rvalid), 32'd0);
                    check_eq($sformatf("d%0d.rst_err", g), 32'(err), 32'd0);
                    check_eq($sformatf("d%0d.rst_rdata", g), rdata, 32'd0);
                end else begin
                    fire = (sb.size() != 0) && (sb[0].due == cyc);
                    check_eq($sformatf("d%0d.rvalid", g), 32'(rvalid), 32'(fire));
                    if (fire) begin
                        e = sb.pop_front();
                        check_eq($sformatf("d%0d.err", g), 32'(err), 32'(e.err));
                        check_eq($sformatf("d%0d.rdata", g), rdata, e.data);
                    end else begin
                        check_eq($sformatf("d%0d.rdata_idle", g), rdata, 32'd0);
                    end
                    off  = addr_a[g] - Base;
                    hit  = (off < 32'h0001_0000);
                    algn = (addr_a[g][1:0] == 2'b00);
                    egnt = req_a[g] && !stall_a[g] && ((mcnt < Mo) || fire);
                    check_eq($sformatf("d%0d.gnt", g), 32'(gnt), 32'(egnt));
                    check_eq($sformatf("d%0d.mem_req", g), 32'(mreq), 32'(egnt && hit && algn));
                    if (egnt && hit && algn) begin
                        check_eq($sformatf("d%0d.mem_addr", g), 32'(maddr), 32'(off[15:2]));
                    end
                    if (egnt) begin
                        sb.push_back('{due: cyc + Rl, err: !(hit && algn),
                                       data: (hit && algn) ? sram_word(off[15:2]) : 32'h0});
                    end
                    mcnt = mcnt + (egnt ? 1 : 0) - (fire ? 1 : 0);
                    if (done && !drained) begin
                        drained = 1'b1;
                        check_eq($sformatf("d%0d.drain", g), 32'(sb.size()), 32'd0);
                    end
                end
            end
        end
    endgenerate

    // One bus cycle on instance g; the other instances idle.
    task automatic step(input int g, input logic r, input logic [31:0] a, input logic s);
        @(posedge clk);
        #1;
        for (int k = 0; k < NDut; k++) begin
            req_a[k]   = 1'b0;
            stall_a[k] = 1'b0;
        end
        req_a[g]   = r;
        addr_a[g]  = a;
        stall_a[g] = s;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic random_burst(input int g, input int n);
        logic [31:0] a;
        int          kind;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0:       a = base_of(g) + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                1:       a = base_of(g) + 32'h0001_0000 + 32'($urandom_range(0, 15) * 4);
                2:       a = base_of(g) - 32'd4;
                default: a = base_of(g) + 32'($urandom_range(0, 255) * 4);
            endcase
            step(g, ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDut; k++) begin
            req_a[k]   = 1'b0;
            addr_a[k]  = 32'h0;
            stall_a[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch of word 0, then a linear stream.
        step(0, 1'b1, 32'h0, 1'b0);
        idle(2);
        for (int k = 0; k < 4; k++) step(0, 1'b1, 32'(k * 4), 1'b0);
        idle(2);

        // Error responses: out of range, misaligned, wrapped high address.
        step(0, 1'b1, 32'h0001_0000, 1'b0);
        step(0, 1'b1, 32'h0000_0002, 1'b0);
        step(0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(2);

        // Stall with request held while an earlier response is in flight.
        step(0, 1'b1, 32'h10, 1'b0);
        repeat (5) step(0, 1'b1, 32'h20, 1'b1);
        step(0, 1'b1, 32'h20, 1'b0);
        idle(2);
        random_burst(0, 40);
        idle(3);

        // Long latency with a single outstanding slot.
        for (int k = 0; k < 12; k++) step(1, 1'b1, 32'h100 + 32'(k * 4), 1'b0);
        repeat (4) step(1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (4) step(1, 1'b1, 32'h0000_0000, 1'b0);
        repeat (4) step(1, 1'b1, 32'h0001_0100, 1'b0);
        idle(4);
        random_burst(1, 40);
        idle(5);

        // Reset pulse with two grants in flight.
        step(2, 1'b1, 32'h8, 1'b0);
        step(2, 1'b1, 32'hC, 1'b0);
        step(2, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_a[2]  = 1'b1;
        addr_a[2] = 32'h40;
        step(2, 1'b0, 32'h0, 1'b0);
        idle(3);
        random_burst(2, 40);
        idle(8);

        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
